// File: rtl/i2c_master_ctrl_if.sv
// Purpose: host/bus-side signal bundle of the I2C master sequencer.
//   master : the sequencer's view (drives cmd_ready, SCL/SDA controls, state/count, status).
//   slave  : the view of the host and the bit datapath (drives commands and sampled bus lines).
// Signals:
//   cmd_valid, cmd_rw, cmd_ready          command handshake
//   sda_in, scl_sense                     sampled bus lines
//   i2c_scl_in, i2c_scl_en, i2c_write_en  bus clock and drive enables
//   state[7:0], count[3:0], rw            datapath control
//   done, nack                            transaction status
interface i2c_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_rw;
  logic       cmd_ready;
  logic       sda_in;
  logic       scl_sense;
  logic       i2c_scl_in;
  logic       i2c_scl_en;
  logic       i2c_write_en;
  logic [7:0] state;
  logic [3:0] count;
  logic       rw;
  logic       done;
  logic       nack;

  modport master (
    input  cmd_valid, cmd_rw, sda_in, scl_sense,
    output cmd_ready, i2c_scl_in, i2c_scl_en, i2c_write_en,
           state, count, rw, done, nack
  );

  modport slave (
    output cmd_valid, cmd_rw, sda_in, scl_sense,
    input  cmd_ready, i2c_scl_in, i2c_scl_en, i2c_write_en,
           state, count, rw, done, nack
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Purpose: system-clock sequencer in front of the I2C bit datapath. Divides clk
//   into a free-running SCL, steps the datapath state/count on each SCL rising
//   edge (tick), samples ACK bits and reports done/nack. One byte per command.
// Ports:
//   clk, resetN : system clock, asynchronous active-low reset
//   bus         : i2c_master_ctrl_if.master (handshake, bus lines, datapath control, status)
// Parameter DIV: clk cycles per SCL half-period (2..255).
// Optional feature macro I2C_STRETCH_EN: when defined, a slave holding SCL low
//   during a released-high phase freezes the divider (clock stretching).
module i2c_master_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic               clk,
  input  logic               resetN,
  i2c_master_ctrl_if.master  bus
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned STATE_W = 8;
  localparam int unsigned COUNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 8'd0,
    START      = 8'd1,
    ADDRESS    = 8'd2,
    READ_ACK   = 8'd3,
    WRITE_DATA = 8'd4,
    READ_ACK2  = 8'd5,
    READ_DATA  = 8'd6,
    WRITE_ACK2 = 8'd7,
    STOP       = 8'd8
  } state_t;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               scl_q, scl_d;
  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               rw_q, rw_d;
  logic               pending_q, pending_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               nack_q, nack_d;
  logic               scl_en_q, scl_en_d;
  logic               write_en_q, write_en_d;
  logic               freeze_c, wrap_c, tick_c, accept_c;

  // Slave may hold SCL low only while we have released it during a high phase.
`ifdef I2C_STRETCH_EN
  assign freeze_c = scl_q && !scl_en_q && !bus.scl_sense;
`else
  logic unused_scl_sense;
  assign unused_scl_sense = bus.scl_sense;
  assign freeze_c = 1'b0;
`endif

  assign wrap_c   = (div_cnt_q == DIV_W'(DIV - 1)) && !freeze_c;
  assign tick_c   = wrap_c && !scl_q;
  assign accept_c = (state_q == IDLE) && ready_q && bus.cmd_valid;

  // Next-state, count and status; every update except accept waits for a tick.
  always_comb begin
    div_cnt_d = wrap_c ? '0 : (freeze_c ? div_cnt_q : DIV_W'(div_cnt_q + 8'd1));
    scl_d     = wrap_c ? ~scl_q : scl_q;
    state_d   = state_q;
    count_d   = count_q;
    rw_d      = rw_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    nack_d    = nack_q;

    if (accept_c) begin
      rw_d      = bus.cmd_rw;
      nack_d    = 1'b0;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end

    if (tick_c) begin
      case (state_q)
        IDLE: begin
          // pending_q is registered, so a same-cycle accept waits one more tick.
          if (pending_q) begin
            state_d   = START;
            count_d   = 4'd7;
            pending_d = 1'b0;
          end
        end
        START: begin
          state_d = ADDRESS;
          count_d = 4'd7;
        end
        ADDRESS: begin
          if (count_q == 4'd0) begin
            state_d = READ_ACK;
            count_d = 4'd7;
          end else begin
            count_d = COUNT_W'(count_q - 4'd1);
          end
        end
        READ_ACK: begin
          count_d = 4'd7;
          if (bus.sda_in) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            state_d = rw_q ? READ_DATA : WRITE_DATA;
          end
        end
        WRITE_DATA: begin
          if (count_q == 4'd0) begin
            state_d = READ_ACK2;
            count_d = 4'd7;
          end else begin
            count_d = COUNT_W'(count_q - 4'd1);
          end
        end
        READ_ACK2: begin
          nack_d  = bus.sda_in;
          state_d = STOP;
          count_d = 4'd7;
        end
        READ_DATA: begin
          if (count_q == 4'd0) begin
            state_d = WRITE_ACK2;
            count_d = 4'd7;
          end else begin
            count_d = COUNT_W'(count_q - 4'd1);
          end
        end
        WRITE_ACK2: begin
          state_d = STOP;
          count_d = 4'd7;
        end
        STOP: begin
          state_d = IDLE;
          count_d = 4'd7;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
        default: begin
          state_d   = IDLE;
          count_d   = 4'd7;
          pending_d = 1'b0;
          ready_d   = 1'b1;
        end
      endcase
    end

    // Bus enables follow the state they will be registered with.
    scl_en_d   = (state_d == IDLE) || (state_d == START) || (state_d == STOP);
    write_en_d = !((state_d == READ_ACK) || (state_d == READ_ACK2) || (state_d == READ_DATA));
  end

  // State and output registers; reset releases both bus lines high.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt_q  <= '0;
      scl_q      <= 1'b1;
      state_q    <= IDLE;
      count_q    <= 4'd7;
      rw_q       <= 1'b0;
      pending_q  <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      scl_en_q   <= 1'b1;
      write_en_q <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      scl_q      <= scl_d;
      state_q    <= state_d;
      count_q    <= count_d;
      rw_q       <= rw_d;
      pending_q  <= pending_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      scl_en_q   <= scl_en_d;
      write_en_q <= write_en_d;
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.i2c_scl_in   = scl_q;
  assign bus.i2c_scl_en   = scl_en_q;
  assign bus.i2c_write_en = write_en_q;
  assign bus.state        = state_q;
  assign bus.count        = count_q;
  assign bus.rw           = rw_q;
  assign bus.done         = done_q;
  assign bus.nack         = nack_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Purpose: self-checking bench for i2c_master_ctrl (DIV = 4). Expected
//   state/count/enable steps and final nack values are queued when a command
//   is issued and compared as the sequencer produces them.
module tb_i2c_master_ctrl;

  logic clk;
  logic resetN;
  i2c_master_ctrl_if bus ();

  i2c_master_ctrl #(.DIV(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int accepts     = 0;
  int dones       = 0;
  logic mon_off   = 1'b1;

  logic [13:0] exp_q[$];
  logic        nack_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {state, count, scl_en, write_en} tuple for one step.
  function automatic logic [13:0] ent(input logic [7:0] s, input logic [3:0] c);
    logic se, we;
    se = (s == 8'd0) || (s == 8'd1) || (s == 8'd8);
    we = !((s == 8'd3) || (s == 8'd5) || (s == 8'd6));
    return {s, c, se, we};
  endfunction

  task automatic push_txn(input logic rw, input logic a1, input logic a2);
    exp_q.push_back(ent(8'd1, 4'd7));
    for (int i = 7; i >= 0; i--) exp_q.push_back(ent(8'd2, 4'(i)));
    exp_q.push_back(ent(8'd3, 4'd7));
    if (!a1) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(ent(rw ? 8'd6 : 8'd4, 4'(i)));
      exp_q.push_back(ent(rw ? 8'd7 : 8'd5, 4'd7));
    end
    exp_q.push_back(ent(8'd8, 4'd7));
    exp_q.push_back(ent(8'd0, 4'd7));
    nack_q.push_back(a1 | (!rw & a2));
  endtask

  // Accept counter, sampled at the active edge where the handshake completes.
  always @(posedge clk) begin
    if (resetN && bus.cmd_valid && bus.cmd_ready) accepts++;
  end

  // Monitor: compare every state/count step against the queue.
  initial begin
    logic [11:0] prev_sc;
    logic [11:0] cur;
    logic [13:0] e;
    int dur;
    logic done_next;
    prev_sc = {8'd0, 4'd7};
    dur = 0;
    done_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetN || mon_off) begin
        prev_sc = {8'd0, 4'd7};
        dur = 0;
        done_next = 1'b0;
      end else begin
        dur++;
        if (done_next) begin
          check("done_width", 32'(bus.done), 32'd0);
          done_next = 1'b0;
        end
        if (bus.done) dones++;
        cur = {bus.state, bus.count};
        if (cur != prev_sc) begin
          if (exp_q.size() == 0) begin
            check("step_queue", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("step", 32'({bus.state, bus.count, bus.i2c_scl_en, bus.i2c_write_en}), 32'(e));
          end
          if (prev_sc[11:4] != 8'd0) check("step_len", 32'(dur), 32'd8);
          if (bus.state == 8'd0) begin
            check("done_at_idle", 32'(bus.done), 32'd1);
            done_next = 1'b1;
            if (nack_q.size() == 0) check("nack_queue", 32'(nack_q.size()), 32'd1);
            else check("nack", 32'(bus.nack), 32'(nack_q.pop_front()));
          end
          prev_sc = cur;
          dur = 0;
        end
      end
    end
  end

  // Issue a command and play the slave until n_done transactions complete.
  task automatic run(input int n_done, input logic hold, input logic a1, input logic a2);
    int seen;
    int acc0;
    int cyc;
    seen = 0;
    acc0 = accepts;
    cyc  = 0;
    bus.cmd_valid = 1'b1;
    while (seen < n_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!hold && accepts > acc0) bus.cmd_valid = 1'b0;
      if (bus.done) begin
        seen++;
        if (seen == n_done) bus.cmd_valid = 1'b0;
      end
      case (bus.state)
        8'd3:    bus.sda_in = a1;
        8'd5:    bus.sda_in = a2;
        8'd6:    bus.sda_in = 1'($urandom_range(0, 1));
        default: bus.sda_in = 1'b1;
      endcase
    end
    bus.cmd_valid = 1'b0;
    check("txn_done", 32'(seen), 32'(n_done));
    check("txn_accepts", 32'(accepts - acc0), 32'(n_done));
  endtask

  initial begin
    int acc_before;
    int waited;
    resetN        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.sda_in    = 1'b1;
    bus.scl_sense = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_count", 32'(bus.count), 32'd7);
    check("rst_scl_in", 32'(bus.i2c_scl_in), 32'd1);
    check("rst_scl_en", 32'(bus.i2c_scl_en), 32'd1);
    check("rst_write_en", 32'(bus.i2c_write_en), 32'd1);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_nack", 32'(bus.nack), 32'd0);
    check("rst_rw", 32'(bus.rw), 32'd0);
    resetN  = 1'b1;
    mon_off = 1'b0;
    repeat (5) @(negedge clk);

    // Write, both ACKs low.
    bus.cmd_rw = 1'b0;
    push_txn(1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0);
    check("rw_write", 32'(bus.rw), 32'd0);

    // Read, address ACKed.
    bus.cmd_rw = 1'b1;
    push_txn(1'b1, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b1);
    check("rw_read", 32'(bus.rw), 32'd1);

    // Address NACK on a write, then on a read.
    bus.cmd_rw = 1'b0;
    push_txn(1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b1, 1'b0);
    bus.cmd_rw = 1'b1;
    push_txn(1'b1, 1'b1, 1'b0);
    run(1, 1'b0, 1'b1, 1'b0);

    // Data NACK on a write; nack must be cleared by the next accept.
    bus.cmd_rw = 1'b0;
    push_txn(1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // cmd_valid held through two back-to-back transactions.
    bus.cmd_rw = 1'b1;
    push_txn(1'b1, 1'b0, 1'b0);
    push_txn(1'b1, 1'b0, 1'b0);
    acc_before = accepts;
    run(2, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("hold_no_extra_accept", 32'(accepts - acc_before), 32'd2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_total", 32'(dones), 32'd7);

    // Reset mid-ADDRESS at count 3.
    mon_off = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_valid = 1'b1;
    waited = 0;
    while (!(bus.state == 8'd2 && bus.count == 4'd3) && waited < 300) begin
      @(negedge clk);
      waited++;
      if (!bus.cmd_ready) bus.cmd_valid = 1'b0;
    end
    check("reach_addr3", 32'({bus.state, bus.count}), 32'({8'd2, 4'd3}));
    resetN = 1'b0;
    #1;
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_count", 32'(bus.count), 32'd7);
    check("mid_rst_scl_en", 32'(bus.i2c_scl_en), 32'd1);
    check("mid_rst_write_en", 32'(bus.i2c_write_en), 32'd1);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_rst_scl_in", 32'(bus.i2c_scl_in), 32'd1);
    @(negedge clk);
    resetN = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", 32'(bus.state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
